// File: rtl/sseg_capture_if.sv
// sseg_capture_if: bus between a multiplexed seven-segment source and the
// sseg_capture monitor. The master drives the display lines and err_clr.
// The slave (the monitor) returns the recovered digit values and flags.
interface sseg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              sseg;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic [NUM_DIGITS-1:0]   pattern_err;
    logic                    update;

    modport master (
        output sseg, digit_sel, err_clr,
        input  hex_out, digit_valid, pattern_err, update
    );

    modport slave (
        input  sseg, digit_sel, err_clr,
        output hex_out, digit_valid, pattern_err, update
    );
endinterface

// File: rtl/sseg_capture.sv
// sseg_capture: monitors a multiplexed seven-segment bus and recovers the hex
// value shown on each digit. Every digit has its own stability filter, so a
// digit commits only after STABLE_CNT consecutive identical samples of it.
// Committed glyphs update hex_out/digit_valid. A stable blank clears
// digit_valid. A stable non-glyph pattern also sets the sticky pattern_err bit.
// Optional build macro: SSEG_ACTIVE_LOW_EN inverts sseg and digit_sel at the
// input, for common-anode boards.
module sseg_capture #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sseg_capture_if.slave bus
);

    localparam logic [3:0] STABLE_W = 4'(STABLE_CNT);

    typedef enum logic [1:0] {
        PAT_BLANK,
        PAT_GLYPH,
        PAT_ILLEGAL
    } pat_kind_e;

    typedef struct packed {
        pat_kind_e  kind;
        logic [3:0] hex;
    } decode_t;

    // Map one segment pattern to its glyph value or to the blank/illegal class.
    function automatic decode_t decode_seg(input logic [6:0] seg);
        decode_t d;
        d.kind = PAT_GLYPH;
        d.hex  = 4'h0;
        case (seg)
            7'h3F: d.hex = 4'h0;
            7'h06: d.hex = 4'h1;
            7'h5B: d.hex = 4'h2;
            7'h4F: d.hex = 4'h3;
            7'h66: d.hex = 4'h4;
            7'h6D: d.hex = 4'h5;
            7'h7D: d.hex = 4'h6;
            7'h07: d.hex = 4'h7;
            7'h7F: d.hex = 4'h8;
            7'h67: d.hex = 4'h9;
            7'h77: d.hex = 4'hA;
            7'h7C: d.hex = 4'hB;
            7'h39: d.hex = 4'hC;
            7'h5E: d.hex = 4'hD;
            7'h79: d.hex = 4'hE;
            7'h71: d.hex = 4'hF;
            7'h00: d.kind = PAT_BLANK;
            default: d.kind = PAT_ILLEGAL;
        endcase
        return d;
    endfunction

    // Input polarity conditioning
    logic [6:0]            sseg_s;
    logic [NUM_DIGITS-1:0] sel_s;

`ifdef SSEG_ACTIVE_LOW_EN
    assign sseg_s = ~bus.sseg;
    assign sel_s  = ~bus.digit_sel;
`else
    assign sseg_s = bus.sseg;
    assign sel_s  = bus.digit_sel;
`endif

    // Only an exactly one-hot select is a usable sample. Zero-hot and
    // multi-hot cycles are ignored so that ghosting between digits cannot
    // feed a filter.
    logic sample_vld;
    assign sample_vld = (sel_s != '0) &&
                        ((sel_s & (sel_s - (NUM_DIGITS)'(1))) == '0);

    // Per-digit filter state
    logic [NUM_DIGITS-1:0][6:0] last_q;
    logic [NUM_DIGITS-1:0][3:0] cnt_q;
    logic [NUM_DIGITS-1:0][3:0] cnt_d;
    logic [NUM_DIGITS-1:0]      hit;
    logic [NUM_DIGITS-1:0]      commit;

    // Registered outputs
    logic [NUM_DIGITS-1:0][3:0] hex_q;
    logic [NUM_DIGITS-1:0]      valid_q;
    logic [NUM_DIGITS-1:0]      perr_q;
    logic                       update_q;

    decode_t cur;
    assign cur = decode_seg(sseg_s);

    // Next count per digit, and whether this sample makes the count reach STABLE_CNT
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        hit    = '0;
        commit = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hit[i] = sample_vld && sel_s[i];
            if (sseg_s != last_q[i]) begin
                cnt_d[i] = 4'd1;
            end else if (cnt_q[i] < STABLE_W) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
            // A count that is already saturated on an unchanged pattern does
            // not commit again. A changed pattern restarts the count, which
            // commits at once when STABLE_CNT is 1.
            commit[i] = hit[i] && (cnt_d[i] == STABLE_W) &&
                        ((sseg_s != last_q[i]) || (cnt_q[i] != STABLE_W));
        end
    end

    // Filter state update for the sampled digit only
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the per-digit last/count registers are individual flops, not a RAM, so they are reset explicitly to stop stale counts from surviving a reset.
        if (!rst_n) begin
            last_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (hit[i]) begin
                    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values, whatever order the statements are in.
                    last_q[i] <= sseg_s;
                    cnt_q[i]  <= cnt_d[i];
                end
            end
        end
    end

    // Commit results into the outputs. The illegal-pattern set is written
    // after err_clr, so set wins for a digit that commits in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_q    <= '0;
            valid_q  <= '0;
            perr_q   <= '0;
            update_q <= 1'b0;
        end else begin
            update_q <= |commit;
            if (bus.err_clr) begin
                perr_q <= '0;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit[i]) begin
                    case (cur.kind)
                        PAT_GLYPH: begin
                            hex_q[i]   <= cur.hex;
                            valid_q[i] <= 1'b1;
                        end
                        PAT_BLANK: begin
                            valid_q[i] <= 1'b0;
                        end
                        default: begin
                            valid_q[i] <= 1'b0;
                            perr_q[i]  <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.hex_out     = hex_q;
    assign bus.digit_valid = valid_q;
    assign bus.pattern_err = perr_q;
    assign bus.update      = update_q;

endmodule

// File: tb/tb_sseg_capture.sv
// tb_sseg_capture: directed self-checking bench for sseg_capture with the
// default configuration (4 digits, STABLE_CNT=4, active-high inputs).
module tb_sseg_capture;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sseg_capture_if #(.NUM_DIGITS(4)) bus ();

    sseg_capture #(
        .NUM_DIGITS(4),
        .STABLE_CNT(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare and count. A miss is counted and reported, then the run continues.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge. Return 1 ns after the rising edge,
    // when the outputs are stable.
    task automatic step(input logic [3:0] sel, input logic [6:0] seg, input logic clr);
        @(negedge clk);
        bus.digit_sel = sel;
        bus.sseg      = seg;
        bus.err_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.sseg      = 7'h00;
        bus.digit_sel = 4'b0000;
        bus.err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_hex", 32'(bus.hex_out), 32'h0000);
        check("rst_valid", 32'(bus.digit_valid), 32'h0);
        check("rst_err", 32'(bus.pattern_err), 32'h0);
        check("rst_update", 32'(bus.update), 32'h0);

        // Single-digit commit of glyph 3 on digit 0
        for (int k = 1; k <= 3; k++) begin
            step(4'b0001, 7'h4F, 1'b0);
            check("single_pre_update", 32'(bus.update), 32'h0);
        end
        check("single_pre_valid", 32'(bus.digit_valid), 32'h0);
        step(4'b0001, 7'h4F, 1'b0);
        check("single_update", 32'(bus.update), 32'h1);
        check("single_hex", 32'(bus.hex_out), 32'h0003);
        check("single_valid", 32'(bus.digit_valid), 32'h1);
        step(4'b0001, 7'h4F, 1'b0);
        check("single_saturated_no_update", 32'(bus.update), 32'h0);
        check("single_hold_hex", 32'(bus.hex_out), 32'h0003);

        // Round-robin scan: digits 0..3 show 1,2,3,4, four rounds
        for (int r = 0; r < 4; r++) begin
            step(4'b0001, 7'h06, 1'b0);
            check("rr_update_d0", 32'(bus.update), (r == 3) ? 32'h1 : 32'h0);
            step(4'b0010, 7'h5B, 1'b0);
            check("rr_update_d1", 32'(bus.update), (r == 3) ? 32'h1 : 32'h0);
            step(4'b0100, 7'h4F, 1'b0);
            check("rr_update_d2", 32'(bus.update), (r == 3) ? 32'h1 : 32'h0);
            step(4'b1000, 7'h66, 1'b0);
            check("rr_update_d3", 32'(bus.update), (r == 3) ? 32'h1 : 32'h0);
        end
        check("rr_hex", 32'(bus.hex_out), 32'h4321);
        check("rr_valid", 32'(bus.digit_valid), 32'hF);

        // Glitch rejection on digit 0: three 6s, one 2, three more 2s
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 7'h7D, 1'b0);
            check("glitch_pre_update", 32'(bus.update), 32'h0);
        end
        check("glitch_no_commit_6", 32'(bus.hex_out), 32'h4321);
        step(4'b0001, 7'h5B, 1'b0);
        check("glitch_first2_no_update", 32'(bus.update), 32'h0);
        for (int k = 0; k < 2; k++) begin
            step(4'b0001, 7'h5B, 1'b0);
            check("glitch_mid_no_update", 32'(bus.update), 32'h0);
        end
        check("glitch_hold_hex", 32'(bus.hex_out), 32'h4321);
        step(4'b0001, 7'h5B, 1'b0);
        check("glitch_commit_update", 32'(bus.update), 32'h1);
        check("glitch_commit_hex", 32'(bus.hex_out), 32'h4322);

        // Illegal pattern 01 stable on digit 1
        for (int k = 0; k < 3; k++) step(4'b0010, 7'h01, 1'b0);
        check("illegal_pre_err", 32'(bus.pattern_err), 32'h0);
        step(4'b0010, 7'h01, 1'b0);
        check("illegal_update", 32'(bus.update), 32'h1);
        check("illegal_err", 32'(bus.pattern_err), 32'h2);
        check("illegal_valid", 32'(bus.digit_valid), 32'hD);
        check("illegal_hex_hold", 32'(bus.hex_out), 32'h4322);
        step(4'b0000, 7'h00, 1'b1);
        check("errclr_clears", 32'(bus.pattern_err), 32'h0);

        // Clear and an illegal commit in the same cycle: the set wins
        for (int k = 0; k < 3; k++) step(4'b0010, 7'h02, 1'b0);
        step(4'b0010, 7'h02, 1'b1);
        check("errclr_set_wins", 32'(bus.pattern_err), 32'h2);
        step(4'b0000, 7'h00, 1'b1);
        check("errclr_again", 32'(bus.pattern_err), 32'h0);

        // Blank commit on digit 3: valid drops and hex holds
        for (int k = 0; k < 4; k++) step(4'b1000, 7'h00, 1'b0);
        check("blank_update", 32'(bus.update), 32'h1);
        check("blank_valid", 32'(bus.digit_valid), 32'h5);
        check("blank_hex_hold", 32'(bus.hex_out), 32'h4322);
        check("blank_no_err", 32'(bus.pattern_err), 32'h0);

        // Bad selects are ignored
        for (int k = 0; k < 10; k++) begin
            step(4'b0011, 7'h3F, 1'b0);
            check("multihot_no_update", 32'(bus.update), 32'h0);
        end
        for (int k = 0; k < 10; k++) begin
            step(4'b0000, 7'h3F, 1'b0);
            check("zerohot_no_update", 32'(bus.update), 32'h0);
        end
        check("badsel_hex", 32'(bus.hex_out), 32'h4322);
        check("badsel_valid", 32'(bus.digit_valid), 32'h5);
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 7'h3F, 1'b0);
            check("badsel_then_pre_update", 32'(bus.update), 32'h0);
        end
        step(4'b0001, 7'h3F, 1'b0);
        check("badsel_then_commit", 32'(bus.update), 32'h1);
        check("badsel_then_hex", 32'(bus.hex_out), 32'h4320);

        // Asynchronous reset mid-cycle while update is high, with digit 2 partially counted
        for (int k = 0; k < 2; k++) step(4'b0100, 7'h06, 1'b0);
        step(4'b0001, 7'h7F, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0001, 7'h7F, 1'b0);
        check("pre_reset_update", 32'(bus.update), 32'h1);
        check("pre_reset_hex", 32'(bus.hex_out), 32'h4328);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hex", 32'(bus.hex_out), 32'h0000);
        check("async_rst_valid", 32'(bus.digit_valid), 32'h0);
        check("async_rst_update", 32'(bus.update), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // Digit 2 had two samples of 06 before reset. Those are discarded.
        for (int k = 0; k < 3; k++) begin
            step(4'b0100, 7'h06, 1'b0);
            check("post_rst_no_update", 32'(bus.update), 32'h0);
        end
        step(4'b0100, 7'h06, 1'b0);
        check("post_rst_commit", 32'(bus.update), 32'h1);
        check("post_rst_hex", 32'(bus.hex_out), 32'h0100);
        check("post_rst_valid", 32'(bus.digit_valid), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
